// File: rtl/instr_type_decode_pkg.sv
// Shared definitions for the RV32I instruction-type decoder: opcodes, one-hot
// type bit positions and the decoded entry that travels through the buffer.
package instr_type_decode_pkg;

   typedef enum logic [6:0] {
      OP_R   = 7'b0110011,
      OP_I   = 7'b0010011,
      OP_L   = 7'b0000011,
      OP_S   = 7'b0100011,
      OP_B   = 7'b1100011,
      OP_J   = 7'b1101111,
      OP_JR  = 7'b1100111,
      OP_LUI = 7'b0110111,
      OP_AUI = 7'b0010111
   } opcode_e;

   localparam int TYPE_R    = 0;
   localparam int TYPE_I    = 1;
   localparam int TYPE_L    = 2;
   localparam int TYPE_S    = 3;
   localparam int TYPE_B    = 4;
   localparam int TYPE_J    = 5;
   localparam int TYPE_JR   = 6;
   localparam int TYPE_LUI  = 7;
   localparam int TYPE_AUI  = 8;
   localparam int NUM_TYPES = 9;

   localparam logic [15:0] ILLEGAL_CNT_MAX = 16'hFFFF;

   // Fields are stored already sliced so the consumer never re-decodes the raw word.
   typedef struct packed {
      logic [NUM_TYPES-1:0] instrType;
      logic                 illegal;
      logic [4:0]           rd;
      logic [4:0]           rs1;
      logic [4:0]           rs2;
      logic [2:0]           funct3;
      logic [6:0]           funct7;
      logic [31:0]          pc;
   } decoded_entry_t;

endpackage

// File: rtl/instr_type_decode_if.sv
// Fetch-side and consumer-side handshake bundle for the instruction-type decoder.
// The slave modport is the decoder's view, master is the surrounding pipeline.
interface instr_type_decode_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  out_type;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [31:0] out_pc;
   logic        out_illegal;
   logic [15:0] illegal_cnt;

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_type, out_rd, out_rs1, out_rs2,
             out_funct3, out_funct7, out_pc, out_illegal, illegal_cnt
   );

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_type, out_rd, out_rs1, out_rs2,
             out_funct3, out_funct7, out_pc, out_illegal, illegal_cnt
   );

endinterface

// File: rtl/decode_skid_buf.sv
// Two-entry in-order buffer for decoded entries. Head data comes straight from
// storage registers, so nothing on the push side reaches the head combinationally.
module decode_skid_buf #(
   parameter type EntryT = logic
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_flush,
   input  logic       i_push,
   input  EntryT      i_pushData,
   input  logic       i_pop,
   output EntryT      o_headData,
   output logic [1:0] o_count
);

   EntryT      r_mem [2];
   logic       r_wrPtr;
   logic       r_rdPtr;
   logic [1:0] r_count;
   logic       w_doPush;
   logic       w_doPop;

   assign w_doPush = i_push && (r_count != 2'd2);
   assign w_doPop  = i_pop && (r_count != 2'd0);

   // One-bit pointers wrap modulo 2 simply by toggling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wrPtr  <= 1'b0;
         r_rdPtr  <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_wrPtr  <= 1'b0;
         r_rdPtr  <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (w_doPop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_headData = r_mem[r_rdPtr];
   assign o_count    = r_count;

endmodule

// File: rtl/instr_type_decode.sv
// RV32I instruction-type classifier: decodes at acceptance, buffers up to two
// decoded entries in order and counts accepted illegal opcodes (saturating).
module instr_type_decode
   import instr_type_decode_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   instr_type_decode_if.slave    io_dec
);

   decoded_entry_t w_entry;
   decoded_entry_t w_bufHead;
   decoded_entry_t w_head;
   logic [1:0]     w_count;
   logic           w_push;
   logic           w_pop;
   logic           w_outValid;
   logic [15:0]    r_illegalCnt;

   always_comb begin
      w_entry        = '0;
      w_entry.rd     = io_dec.in_instr[11:7];
      w_entry.funct3 = io_dec.in_instr[14:12];
      w_entry.rs1    = io_dec.in_instr[19:15];
      w_entry.rs2    = io_dec.in_instr[24:20];
      w_entry.funct7 = io_dec.in_instr[31:25];
      w_entry.pc     = io_dec.in_pc;
      case (io_dec.in_instr[6:0])
         OP_R:    w_entry.instrType[TYPE_R]   = 1'b1;
         OP_I:    w_entry.instrType[TYPE_I]   = 1'b1;
         OP_L:    w_entry.instrType[TYPE_L]   = 1'b1;
         OP_S:    w_entry.instrType[TYPE_S]   = 1'b1;
         OP_B:    w_entry.instrType[TYPE_B]   = 1'b1;
         OP_J:    w_entry.instrType[TYPE_J]   = 1'b1;
         OP_JR:   w_entry.instrType[TYPE_JR]  = 1'b1;
         OP_LUI:  w_entry.instrType[TYPE_LUI] = 1'b1;
         OP_AUI:  w_entry.instrType[TYPE_AUI] = 1'b1;
         default: w_entry.illegal             = 1'b1;
      endcase
   end

   // Readiness depends only on buffer occupancy and reset, never on the consumer.
   assign io_dec.in_ready = !rst && (w_count < 2'd2);
   assign w_push          = io_dec.in_valid && io_dec.in_ready && !io_dec.flush;
   assign w_outValid      = (w_count != 2'd0);
   assign w_pop           = w_outValid && io_dec.out_ready;

   decode_skid_buf #(
      .EntryT     (decoded_entry_t)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (io_dec.flush),
      .i_push     (w_push),
      .i_pushData (w_entry),
      .i_pop      (w_pop),
      .o_headData (w_bufHead),
      .o_count    (w_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_illegalCnt <= 16'd0;
      end else if (w_push && w_entry.illegal && (r_illegalCnt != ILLEGAL_CNT_MAX)) begin
         r_illegalCnt <= r_illegalCnt + 16'd1;
      end
   end

   assign w_head             = w_outValid ? w_bufHead : '0;
   assign io_dec.out_valid   = w_outValid;
   assign io_dec.out_type    = w_head.instrType;
   assign io_dec.out_illegal = w_head.illegal;
   assign io_dec.out_rd      = w_head.rd;
   assign io_dec.out_rs1     = w_head.rs1;
   assign io_dec.out_rs2     = w_head.rs2;
   assign io_dec.out_funct3  = w_head.funct3;
   assign io_dec.out_funct7  = w_head.funct7;
   assign io_dec.out_pc      = w_head.pc;
   assign io_dec.illegal_cnt = r_illegalCnt;

endmodule

// File: tb/tb_instr_type_decode.sv
// Directed bench for instr_type_decode: a queue-based reference model is compared
// against the outputs every falling edge, with literal checks pinning key scenarios.
module tb_instr_type_decode;

   typedef struct packed {
      logic [8:0]  typ;
      logic        ill;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] pc;
   } exp_t;

   localparam logic [31:0] ADD  = 32'h00B50533;
   localparam logic [31:0] LUI  = 32'h123450B7;
   localparam logic [31:0] JAL  = 32'h0000006F;
   localparam logic [31:0] SW   = 32'h00A12023;
   localparam logic [31:0] ADDI = 32'h00100093;
   localparam logic [31:0] BEQ  = 32'h00B50463;
   localparam logic [31:0] BAD  = 32'hFFFFFFFF;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   expIllegal;
   exp_t modelQ [$];
   exp_t modelEntry;
   exp_t modelHead;
   bit   modelPush;
   bit   modelPop;

   logic [31:0] mixTable [12];
   logic [6:0]  opTable  [9];

   instr_type_decode_if dec();

   instr_type_decode u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_dec (dec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Type bit i belongs to the i-th opcode in this table; anything else is illegal.
   function automatic exp_t predict(input logic [31:0] instr, input logic [31:0] pc);
      exp_t e;
      e     = '0;
      e.ill = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (instr[6:0] == opTable[i]) begin
            e.typ = 9'd1 << i;
            e.ill = 1'b0;
         end
      end
      e.rd  = instr[11:7];
      e.f3  = instr[14:12];
      e.rs1 = instr[19:15];
      e.rs2 = instr[24:20];
      e.f7  = instr[31:25];
      e.pc  = pc;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                                input logic outRdy, input logic fl);
      dec.in_valid  = valid;
      dec.in_instr  = instr;
      dec.in_pc     = pc;
      dec.out_ready = outRdy;
      dec.flush     = fl;
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         modelQ.delete();
         expIllegal = 0;
      end else begin
         modelPush = dec.in_valid && (modelQ.size() < 2) && !dec.flush;
         modelPop  = (modelQ.size() > 0) && dec.out_ready;
         if (dec.flush) begin
            modelQ.delete();
         end else begin
            if (modelPop) void'(modelQ.pop_front());
            if (modelPush) begin
               modelEntry = predict(dec.in_instr, dec.in_pc);
               modelQ.push_back(modelEntry);
               if (modelEntry.ill && expIllegal < 65535) expIllegal++;
            end
         end
      end
   end

   always @(negedge clk) begin
      modelHead = (modelQ.size() > 0) ? modelQ[0] : '0;
      checkOutput("inReady",    32'(dec.in_ready),    32'(!rst && modelQ.size() < 2));
      checkOutput("outValid",   32'(dec.out_valid),   32'(modelQ.size() > 0));
      checkOutput("outType",    32'(dec.out_type),    32'(modelHead.typ));
      checkOutput("outIllegal", 32'(dec.out_illegal), 32'(modelHead.ill));
      checkOutput("outRd",      32'(dec.out_rd),      32'(modelHead.rd));
      checkOutput("outRs1",     32'(dec.out_rs1),     32'(modelHead.rs1));
      checkOutput("outRs2",     32'(dec.out_rs2),     32'(modelHead.rs2));
      checkOutput("outFunct3",  32'(dec.out_funct3),  32'(modelHead.f3));
      checkOutput("outFunct7",  32'(dec.out_funct7),  32'(modelHead.f7));
      checkOutput("outPc",      dec.out_pc,           modelHead.pc);
      checkOutput("illegalCnt", 32'(dec.illegal_cnt), 32'(expIllegal[15:0]));
   end

   initial begin
      checks     = 0;
      failures   = 0;
      expIllegal = 0;
      opTable  = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      mixTable = '{32'h00100093, 32'h00052283, 32'h00A12023, 32'h00B50463,
                   32'h0080006F, 32'h000080E7, 32'h00001517, 32'h0000000B,
                   32'h00000073, 32'h40B50533, 32'h000012B7, 32'h00C58593};
      rst           = 1'b1;
      dec.in_valid  = 1'b0;
      dec.in_instr  = 32'd0;
      dec.in_pc     = 32'd0;
      dec.out_ready = 1'b0;
      dec.flush     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetOutValid",   32'(dec.out_valid),   32'd0);
      checkOutput("resetInReady",    32'(dec.in_ready),    32'd0);
      checkOutput("resetIllegalCnt", 32'(dec.illegal_cnt), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("postResetInReady", 32'(dec.in_ready), 32'd1);

      $display("[TB] single add, latency one");
      applyStimulus(1, ADD, 32'h100, 1, 0);
      checkOutput("addType", 32'(dec.out_type), 32'h001);
      checkOutput("addRd",   32'(dec.out_rd),   32'd10);
      checkOutput("addRs1",  32'(dec.out_rs1),  32'd10);
      checkOutput("addRs2",  32'(dec.out_rs2),  32'd11);
      checkOutput("addPc",   dec.out_pc,        32'h100);
      applyStimulus(0, 32'd0, 32'd0, 1, 0);
      checkOutput("addDrained", 32'(dec.out_valid), 32'd0);

      $display("[TB] lui then jal with consumer stalled");
      applyStimulus(1, LUI, 32'h104, 0, 0);
      checkOutput("oneAcceptInReady", 32'(dec.in_ready), 32'd1);
      applyStimulus(1, JAL, 32'h108, 0, 0);
      checkOutput("fullInReady", 32'(dec.in_ready), 32'd0);
      checkOutput("stallHeadType", 32'(dec.out_type), 32'h080);
      applyStimulus(0, 32'd0, 32'd0, 0, 0);
      checkOutput("stallStableType", 32'(dec.out_type), 32'h080);
      checkOutput("stallStablePc",   dec.out_pc,        32'h104);
      applyStimulus(0, 32'd0, 32'd0, 1, 0);
      checkOutput("secondType", 32'(dec.out_type), 32'h020);
      applyStimulus(0, 32'd0, 32'd0, 1, 0);
      checkOutput("pairDrained", 32'(dec.out_valid), 32'd0);

      $display("[TB] push and pop together at one entry");
      applyStimulus(1, ADDI, 32'h10C, 0, 0);
      checkOutput("addiType", 32'(dec.out_type), 32'h002);
      applyStimulus(1, SW, 32'h110, 1, 0);
      checkOutput("swType",    32'(dec.out_type), 32'h008);
      checkOutput("swInReady", 32'(dec.in_ready), 32'd1);
      applyStimulus(0, 32'd0, 32'd0, 1, 0);
      checkOutput("swCountOne", 32'(dec.out_valid), 32'd0);

      $display("[TB] illegal opcode");
      applyStimulus(1, BAD, 32'h114, 0, 0);
      checkOutput("badIllegal", 32'(dec.out_illegal), 32'd1);
      checkOutput("badType",    32'(dec.out_type),    32'd0);
      checkOutput("badCount",   32'(dec.illegal_cnt), 32'd1);
      applyStimulus(0, 32'd0, 32'd0, 1, 0);

      $display("[TB] flush");
      applyStimulus(1, LUI, 32'h118, 0, 0);
      applyStimulus(1, BAD, 32'h11C, 0, 1);
      checkOutput("flushOneValid", 32'(dec.out_valid),   32'd0);
      checkOutput("flushOneCount", 32'(dec.illegal_cnt), 32'd1);
      applyStimulus(1, LUI, 32'h120, 0, 0);
      applyStimulus(1, JAL, 32'h124, 0, 0);
      applyStimulus(1, BAD, 32'h128, 0, 1);
      checkOutput("flushFullValid",   32'(dec.out_valid),   32'd0);
      checkOutput("flushFullInReady", 32'(dec.in_ready),    32'd1);
      checkOutput("flushFullCount",   32'(dec.illegal_cnt), 32'd1);

      $display("[TB] mixed stream");
      for (int i = 0; i < 12; i++) begin
         applyStimulus((i % 4) != 3, mixTable[i], 32'h200 + 32'(i * 4), (i % 3) != 1, 0);
      end
      repeat (3) applyStimulus(0, 32'd0, 32'd0, 1, 0);

      $display("[TB] illegal count saturation");
      for (int i = 0; i < 70000 && expIllegal < 65535; i++) begin
         applyStimulus(1, BAD, 32'(i), 1, 0);
      end
      checkOutput("satReached", 32'(dec.illegal_cnt), 32'h0000FFFF);
      repeat (3) applyStimulus(1, BAD, 32'hABC, 1, 0);
      checkOutput("satHeld", 32'(dec.illegal_cnt), 32'h0000FFFF);
      repeat (2) applyStimulus(0, 32'd0, 32'd0, 1, 0);

      $display("[TB] reset mid-stream");
      applyStimulus(1, LUI, 32'h300, 0, 0);
      applyStimulus(1, JAL, 32'h304, 0, 0);
      dec.in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rstOutValid",   32'(dec.out_valid),   32'd0);
      checkOutput("rstOutType",    32'(dec.out_type),    32'd0);
      checkOutput("rstOutPc",      dec.out_pc,           32'd0);
      checkOutput("rstOutRd",      32'(dec.out_rd),      32'd0);
      checkOutput("rstInReady",    32'(dec.in_ready),    32'd0);
      checkOutput("rstIllegalCnt", 32'(dec.illegal_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("afterRstInReady", 32'(dec.in_ready), 32'd1);
      applyStimulus(1, BEQ, 32'h400, 1, 0);
      checkOutput("beqType", 32'(dec.out_type), 32'h010);
      checkOutput("beqPc",   dec.out_pc,        32'h400);
      applyStimulus(0, 32'd0, 32'd0, 1, 0);
      checkOutput("beqDrained", 32'(dec.out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_type_decode.md
INSTR_TYPE_DECODE -- requirements
Module: instr_type_decode

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: fetch side presents an instruction.
REQ-004 SHALL have port in_ready, output, 1 bit: the block can accept an instruction.
REQ-005 SHALL have port in_instr, input, 32 bits: raw RV32I instruction word.
REQ-006 SHALL have port in_pc, input, 32 bits: PC of in_instr.
REQ-007 SHALL have port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-008 SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer (control decode stage) accepts the head entry.
REQ-010 SHALL have port out_type, output, 9 bits: one-hot type.
- Bit order: [0]R [1]I [2]L [3]S [4]B [5]J [6]Jr [7]lui [8]aui.
REQ-011 SHALL have these outputs, straight bit-slices of the head entry's instruction: out_rd (5 bits), out_rs1 (5), out_rs2 (5), out_funct3 (3), out_funct7 (7).
REQ-012 SHALL have port out_pc, output, 32 bits: PC of the head entry.
REQ-013 SHALL have port out_illegal, output, 1 bit: the head entry's opcode is unrecognised.
REQ-014 SHALL have port illegal_cnt, output, 16 bits: saturating count of illegal instructions accepted.

Function
REQ-015 SHALL perform an input transfer when in_valid and in_ready are both high, and an output transfer when out_valid and out_ready are both high.
REQ-016 SHALL classify instr[6:0] into out_type as follows: 0110011 R, 0010011 I, 0000011 L, 0100011 S, 1100011 B, 1101111 J, 1100111 Jr, 0110111 lui, 0010111 aui.
REQ-017 SHALL, for any other opcode, set out_type = 0 and out_illegal = 1; out_illegal SHALL be 0 for every recognised opcode.
REQ-018 SHALL decode at input-transfer time and store the decoded fields, not the raw word, in a 2-entry in-order buffer.
REQ-019 SHALL present an entry accepted in cycle N with out_valid = 1 in cycle N+1 when the buffer was empty (latency 1), and SHALL never produce a combinational path from in_* to out_*.
REQ-020 SHALL drive in_ready = (count < 2), derived from registers only, with no dependence on out_ready.
REQ-021 SHALL update count as follows on simultaneous push and pop: count unchanged, FIFO order preserved, and a pop at count 1 with push delivers the new entry in the next cycle.
REQ-022 SHALL keep the head entry's outputs stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL drive all out_* fields to 0 when out_valid = 0.
REQ-024 SHALL, on flush, set count to 0 and out_valid = 0 in the next cycle.
- Any input transfer in the flush cycle is discarded.
- illegal_cnt is not changed by a discarded entry.
REQ-025 SHALL increment illegal_cnt on each accepted (non-discarded) illegal instruction, saturating at 16'hFFFF.
REQ-026 SHALL wrap the buffer read and write pointers modulo 2.

Reset
REQ-027 SHALL, while rst = 1, force:
- count = 0, pointers = 0, out_valid = 0, in_ready = 0.
- all out_* = 0, illegal_cnt = 0.
REQ-028 SHALL drive in_ready = 1 in the first cycle after rst deasserts.
REQ-029 SHALL discard any in-flight entry when rst asserts mid-operation, with no transfer completing in that cycle.

Structure
REQ-030 SHALL place the following in a shared package: the opcode constants, the type-bit index constants, and a packed struct for a decoded entry (type, illegal, rd, rs1, rs2, funct3, funct7, pc).
REQ-031 SHALL implement the buffer as sub-module decode_skid_buf (2-entry, parameterised by entry type); classification stays in instr_type_decode.

Verification
REQ-032 SHALL cover scenario: in_instr = 32'h00B50533 (add), in_pc = 32'h100, out_ready = 1 -> next cycle out_type = 9'h001, rd = 10, rs1 = 10, rs2 = 11, out_pc = 32'h100.
REQ-033 SHALL cover scenario: stream lui (32'h123450B7), then jal (32'h0000006F), with out_ready held 0 -> in_ready drops after 2 accepts; on releasing out_ready, outputs are 9'h080 then 9'h020 in order.
REQ-034 SHALL cover scenario: in_instr = 32'hFFFFFFFF -> out_illegal = 1, out_type = 0, illegal_cnt = 1; with illegal_cnt preloaded to FFFF by stimulus, it stays FFFF.
REQ-035 SHALL cover scenario: buffer at count 1, simultaneous push (sw, 32'h00A12023) and pop -> count stays 1, next out_type = 9'h008.
REQ-036 SHALL cover scenario: count 2 plus flush with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, flushed illegal entry not counted.
REQ-037 SHALL cover scenario: rst asserted mid-stream -> all outputs 0 asynchronously; first post-reset instruction (beq, 32'h00B50463) yields 9'h010.
